// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard interlock.
// Holds the state encoding, register-address type, and default pipeline sizing.
package hazard_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic WrtEnable = 1'b1;

  localparam int unsigned RegAddrW = 5;
  typedef logic [RegAddrW-1:0] reg_addr_t;

  localparam int unsigned HzPipeDepth   = 3;
  localparam int unsigned HzFlushCycles = 2;

  typedef enum logic [1:0] {
    HzRun   = 2'd0,
    HzStall = 2'd1,
    HzFlush = 2'd2
  } hz_state_e;

  // x0 is hardwired to zero, so it can never be a pending producer.
  function automatic logic src_hazard(logic used, reg_addr_t addr, logic blocked);
    return used && (addr != '0) && blocked;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: loaded on issue, counts down to readable.
// With HAZARD_FWD_EN a late bit marks load producers so only load-use blocks.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned PIPE_DEPTH = HzPipeDepth
) (
  input  logic                clk_i_Hazard,
  input  logic                rst_i_Hazard,
  input  logic                load_en_i,
  input  reg_addr_t           load_addr_i,
`ifdef HAZARD_FWD_EN
  input  logic                load_late_i,
`endif
  input  reg_addr_t           rs1_i,
  input  reg_addr_t           rs2_i,
  output logic                rs1_block_o,
  output logic                rs2_block_o,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam int unsigned CntW = $clog2(PIPE_DEPTH + 1);

  logic [CntW-1:0] cnt_q [NUM_REGS];
  logic [CntW-1:0] cnt_d [NUM_REGS];

  // A fresh load overrides the decrement of the same entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CntW'(1);
      if (load_en_i && (r != 0) && (load_addr_i == RegAddrW'(r))) cnt_d[r] = CntW'(PIPE_DEPTH);
    end
  end

  always_ff @(posedge clk_i_Hazard) begin
    if (rst_i_Hazard == RstEnable) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy_o[r] = (cnt_q[r] != '0);
  end

`ifdef HAZARD_FWD_EN
  logic [NUM_REGS-1:0] late_q;

  always_ff @(posedge clk_i_Hazard) begin
    if (rst_i_Hazard == RstEnable) begin
      late_q <= '0;
    end else if (load_en_i && (load_addr_i != '0)) begin
      late_q[load_addr_i] <= load_late_i;
    end
  end

  // Forwarding covers everything except the cycle right after a load issues.
  assign rs1_block_o = (cnt_q[rs1_i] == CntW'(PIPE_DEPTH)) && late_q[rs1_i];
  assign rs2_block_o = (cnt_q[rs2_i] == CntW'(PIPE_DEPTH)) && late_q[rs2_i];
`else
  assign rs1_block_o = (cnt_q[rs1_i] != '0);
  assign rs2_block_o = (cnt_q[rs2_i] != '0);
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock and flush sequencer beside ID; drives stall/bubble/flush.
// Build option: HAZARD_FWD_EN reduces the interlock to a one-cycle load-use bubble.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned PIPE_DEPTH   = HzPipeDepth,
  parameter int unsigned FLUSH_CYCLES = HzFlushCycles
) (
  input  logic                clk_i_Hazard,
  input  logic                rst_i_Hazard,
  input  logic                id_valid_i,
  input  reg_addr_t           id_rs1_i,
  input  reg_addr_t           id_rs2_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  reg_addr_t           id_rd_i,
  input  logic                id_regWrite_i,
  input  logic                id_memRead_i,
  input  logic                redirect_i,
  output logic                stall_o,
  output logic                bubble_o,
  output logic                flush_o,
  output logic                issue_o,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

  hz_state_e           state_q, state_d;
  logic [FlushW-1:0]   fcnt_q, fcnt_d;
  logic                rs1_block, rs2_block, hazard, in_reset, load_en;
  logic [NUM_REGS-1:0] busy_raw;

  assign in_reset = (rst_i_Hazard == RstEnable);
  assign load_en  = issue_o && (id_regWrite_i == WrtEnable) && (id_rd_i != '0);

  hazard_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .clk_i_Hazard (clk_i_Hazard),
    .rst_i_Hazard (rst_i_Hazard),
    .load_en_i    (load_en),
    .load_addr_i  (id_rd_i),
`ifdef HAZARD_FWD_EN
    .load_late_i  (id_memRead_i),
`endif
    .rs1_i        (id_rs1_i),
    .rs2_i        (id_rs2_i),
    .rs1_block_o  (rs1_block),
    .rs2_block_o  (rs2_block),
    .busy_o       (busy_raw)
  );

`ifndef HAZARD_FWD_EN
  logic unused_mem_read;
  assign unused_mem_read = id_memRead_i;
`endif

  assign hazard = id_valid_i && (src_hazard(id_rs1_used_i, id_rs1_i, rs1_block) ||
                                 src_hazard(id_rs2_used_i, id_rs2_i, rs2_block));

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (redirect_i) begin
      state_d = HzFlush;
      fcnt_d  = FlushW'(FLUSH_CYCLES);
    end else begin
      case (state_q)
        HzRun:   if (hazard) state_d = HzStall;
        HzStall: if (!hazard) state_d = HzRun;
        HzFlush: begin
          if (fcnt_q <= FlushW'(1)) begin
            state_d = HzRun;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FlushW'(1);
          end
        end
        default: state_d = HzRun;
      endcase
    end
  end

  always_ff @(posedge clk_i_Hazard) begin
    if (in_reset) begin
      state_q <= HzRun;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Priority: reset, then redirect/flush, then operand hazard.
  always_comb begin
    stall_o  = 1'b0;
    bubble_o = !id_valid_i;
    flush_o  = 1'b0;
    issue_o  = id_valid_i;
    if (in_reset) begin
      bubble_o = 1'b1;
      flush_o  = 1'b1;
      issue_o  = 1'b0;
    end else if (redirect_i || (state_q == HzFlush)) begin
      bubble_o = 1'b1;
      flush_o  = 1'b1;
      issue_o  = 1'b0;
    end else if (hazard) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
      issue_o  = 1'b0;
    end
  end

  assign busy_o = in_reset ? '0 : busy_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl with PIPE_DEPTH=3, FLUSH_CYCLES=2.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, reg_write, mem_read, redirect;
  logic        stall, bubble, flush, issue;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .NUM_REGS     (32),
    .PIPE_DEPTH   (3),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_i_Hazard  (clk),
    .rst_i_Hazard  (rst),
    .id_valid_i    (id_valid),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .id_rs1_used_i (rs1_used),
    .id_rs2_used_i (rs2_used),
    .id_rd_i       (rd),
    .id_regWrite_i (reg_write),
    .id_memRead_i  (mem_read),
    .redirect_i    (redirect),
    .stall_o       (stall),
    .bubble_o      (bubble),
    .flush_o       (flush),
    .issue_o       (issue),
    .busy_o        (busy)
  );

  typedef struct {
    logic       rst, val;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr, redir;
    logic       e_stall, e_bubble, e_flush, e_issue;
    int         bidx;
    logic       bval;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic val, logic [4:0] a1, logic u1, logic [4:0] a2,
                              logic u2, logic [4:0] d, logic rw, logic mr, logic redir,
                              logic es, logic eb, logic ef, logic ei, int bidx, logic bval);
    vec_t v;
    v.rst = r; v.val = val; v.rs1 = a1; v.u1 = u1; v.rs2 = a2; v.u2 = u2; v.rd = d;
    v.rw = rw; v.mr = mr; v.redir = redir;
    v.e_stall = es; v.e_bubble = eb; v.e_flush = ef; v.e_issue = ei;
    v.bidx = bidx; v.bval = bval;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic val, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic [4:0] d,
                       input logic rw, input logic mr, input logic redir);
    rst = r; id_valid = val; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; reg_write = rw; mem_read = mr; redirect = redir;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Producer into r9, then a consumer; counts stall cycles before the consumer issues.
  task automatic use_after(input logic is_load, input int exp_stalls, input int tag);
    int  stalls;
    bit  done;
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, is_load, 1'b0);
    @(negedge clk);
    chk("prod_issue", tag, {31'b0, issue}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (issue) done = 1'b1;
      else begin
        stalls++;
        next_cycle();
      end
    end
    chk("use_issued", tag, {31'b0, done}, 32'd1);
    chk("use_stalls", tag, stalls, exp_stalls);
    next_cycle();
    idle();
    repeat (4) next_cycle();
  endtask

  initial begin
    // {rst,val,rs1,u1,rs2,u2,rd,rw,mr,redir} -> {stall,bubble,flush,issue}, busy[bidx]
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0));
    // RAW: addi x5 ; add x6,x5,x1
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0));
    vecs.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 0));
    // x0 destination/source and unused sources reading a busy register
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 10, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 1, 10, 1));
    vecs.push_back(mk(0, 1, 10, 0, 10, 0, 11, 0, 0, 0, 0, 0, 0, 1, 10, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10, 0));
    // Redirect in the second stall cycle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 1, 1, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1, 0, 5, 1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1, 0, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 0));
    // Back-to-back writes of x7, consumer reads rs2=x7
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 7, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 7, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 12, 0, 0, 0, 1, 1, 0, 0, 7, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 12, 0, 0, 0, 1, 1, 0, 0, 7, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 12, 0, 0, 0, 1, 1, 0, 0, 7, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 12, 0, 0, 0, 0, 0, 0, 1, 7, 0));
    // Redirect while in RUN, second redirect reloads the flush length
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 1, 1, 0, 13, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 13, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 13, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 13, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 13, 0));
    // Reset in the first FLUSH cycle with x14 pending
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 1, 14, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 14, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 14, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 14, 0));

    idle();
    rst = 1'b1;
`ifndef HAZARD_FWD_EN
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].val, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].redir);
      @(negedge clk);
      chk("stall",  i, {31'b0, stall},  {31'b0, vecs[i].e_stall});
      chk("bubble", i, {31'b0, bubble}, {31'b0, vecs[i].e_bubble});
      chk("flush",  i, {31'b0, flush},  {31'b0, vecs[i].e_flush});
      chk("issue",  i, {31'b0, issue},  {31'b0, vecs[i].e_issue});
      chk("busy_bit", i, {31'b0, busy[vecs[i].bidx]}, {31'b0, vecs[i].bval});
      if (vecs[i].rst) chk("busy_in_reset", i, busy, 32'd0);
      next_cycle();
    end

    // Reset asserted mid-stall: nothing pending afterwards
    idle();
    next_cycle();
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_stall_stall", 100, {31'b0, stall}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 101, {31'b0, stall}, 32'd0);
    chk("rst_flush", 101, {31'b0, flush}, 32'd1);
    chk("rst_busy",  101, busy, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_issue", 102, {31'b0, issue}, 32'd1);
    chk("post_rst_busy",  102, busy, 32'd0);
    next_cycle();
`else
    next_cycle();
`endif

    idle();
    next_cycle();
`ifdef HAZARD_FWD_EN
    use_after(1'b1, 1, 200);
    use_after(1'b0, 0, 201);
`else
    use_after(1'b1, 3, 200);
    use_after(1'b0, 3, 201);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
